// File: rtl/seq_code_pkg.sv
// Shared types and width helpers for the serial code-entry checker.
package seq_code_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    LOCK    = 2'd2
  } state_t;

  // Width needed for a counter that must hold values 0..max_val (at least 1 bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pulse_edge_det.sv
// One-flop rising-edge detector: rise is high while in=1 and the previous sample was 0.
module pulse_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic prev;

  // Previous-cycle sample of the input, updated every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= in;
  end

  assign rise = in & ~prev;

endmodule

// File: rtl/seq_code_checker.sv
// Serial code-entry checker: collects strobed key bits, compares against code,
// reports a one-cycle res_en with result, times out stale entries and locks out
// after repeated failures.
module seq_code_checker
  import seq_code_pkg::*;
#(
  parameter  int unsigned CODE_LEN    = 4,
  parameter  int unsigned MAX_FAIL    = 3,
  parameter  int unsigned LOCK_CYCLES = 16,
  parameter  int unsigned TIMEOUT     = 64,
  localparam int unsigned FAIL_W      = cnt_w(MAX_FAIL)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pulse_p,
  input  logic                key,
  input  logic [CODE_LEN-1:0] code,
  output logic                result,
  output logic                res_en,
  output logic                locked,
  output logic [FAIL_W-1:0]   fail_cnt
);

  localparam int unsigned BIT_W  = cnt_w(CODE_LEN);
  localparam int unsigned IDLE_W = cnt_w(TIMEOUT);
  localparam int unsigned LOCK_W = cnt_w(LOCK_CYCLES);

  logic accept_c;

  state_t              state, state_nxt;
  logic [CODE_LEN-1:0] shreg, shreg_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_nxt;
  logic [IDLE_W-1:0]   idle_cnt, idle_nxt;
  logic [LOCK_W-1:0]   lock_cnt, lock_nxt;
  logic [FAIL_W-1:0]   fail_nxt;
  logic                result_nxt, res_en_nxt, locked_nxt;

  logic                eval_c;
  logic [CODE_LEN-1:0] word_c;
  logic [FAIL_W-1:0]   fail_inc_c;

  pulse_edge_det u_pulse_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (pulse_p),
    .rise (accept_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
      lock_cnt <= '0;
      fail_cnt <= '0;
      result   <= 1'b0;
      res_en   <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_nxt;
      idle_cnt <= idle_nxt;
      lock_cnt <= lock_nxt;
      fail_cnt <= fail_nxt;
      result   <= result_nxt;
      res_en   <= res_en_nxt;
      locked   <= locked_nxt;
    end
  end

  // Next-state, collection, timeout, lockout and evaluation logic.
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bit_nxt    = bit_cnt;
    idle_nxt   = idle_cnt;
    lock_nxt   = lock_cnt;
    fail_nxt   = fail_cnt;
    result_nxt = result;
    res_en_nxt = 1'b0;
    locked_nxt = locked;
    eval_c     = 1'b0;
    word_c     = CODE_LEN'({shreg, key});
    fail_inc_c = fail_cnt + FAIL_W'(1);

    case (state)
      IDLE: begin
        if (accept_c) begin
          if (CODE_LEN == 1) begin
            eval_c = 1'b1;
          end else begin
            shreg_nxt = word_c;
            bit_nxt   = BIT_W'(1);
            idle_nxt  = '0;
            state_nxt = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (accept_c) begin
          if (bit_cnt == BIT_W'(CODE_LEN - 1)) begin
            eval_c = 1'b1;
          end else begin
            shreg_nxt = word_c;
            bit_nxt   = bit_cnt + BIT_W'(1);
            idle_nxt  = '0;
          end
        end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
          // Stale partial entry: discard silently.
          state_nxt = IDLE;
          shreg_nxt = '0;
          bit_nxt   = '0;
          idle_nxt  = '0;
        end else begin
          idle_nxt = idle_cnt + IDLE_W'(1);
        end
      end
      LOCK: begin
        if (lock_cnt == '0) begin
          state_nxt  = IDLE;
          locked_nxt = 1'b0;
          fail_nxt   = '0;
        end else begin
          lock_nxt = lock_cnt - LOCK_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Final bit of an entry: compare and report.
    if (eval_c) begin
      res_en_nxt = 1'b1;
      shreg_nxt  = '0;
      bit_nxt    = '0;
      idle_nxt   = '0;
      if (word_c == code) begin
        result_nxt = 1'b1;
        fail_nxt   = '0;
        state_nxt  = IDLE;
      end else begin
        result_nxt = 1'b0;
        fail_nxt   = fail_inc_c;
        if (fail_inc_c == FAIL_W'(MAX_FAIL)) begin
          state_nxt  = LOCK;
          locked_nxt = 1'b1;
          lock_nxt   = LOCK_W'(LOCK_CYCLES - 1);
        end else begin
          state_nxt = IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_code_checker.sv
// Scoreboard bench for seq_code_checker with default parameters and code 4'b1011.
module tb_seq_code_checker;

  localparam int unsigned LOCK_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       pulse_p;
  logic       key;
  logic [3:0] code;
  logic       result;
  logic       res_en;
  logic       locked;
  logic [1:0] fail_cnt;

  typedef struct packed {
    logic       result;
    logic       locked;
    logic [1:0] fail;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   lock_len = 0;

  always #5 clk = ~clk;

  seq_code_checker dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_p  (pulse_p),
    .key      (key),
    .code     (code),
    .result   (result),
    .res_en   (res_en),
    .locked   (locked),
    .fail_cnt (fail_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One strobe: high for a cycle, low for a cycle.
  task automatic strobe(input logic k);
    key     = k;
    pulse_p = 1'b1;
    @(negedge clk);
    pulse_p = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_res(input logic r, input logic l, input logic [1:0] f);
    exp_t e;
    e.result = r;
    e.locked = l;
    e.fail   = f;
    exp_q.push_back(e);
  endtask

  task automatic entry(input logic [3:0] b, input logic r, input logic l, input logic [1:0] f);
    expect_res(r, l, f);
    for (int i = 3; i >= 0; i--) strobe(b[i]);
  endtask

  // Monitor: compares each res_en against the scoreboard and measures lockout length.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      lock_len = 0;
    end else begin
      if (res_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_res_en", 32'(res_en), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", 32'(result), 32'(e.result));
          check("locked", 32'(locked), 32'(e.locked));
          check("fail_cnt", 32'(fail_cnt), 32'(e.fail));
        end
      end
      if (locked) begin
        lock_len++;
      end else if (lock_len != 0) begin
        check("lock_len", 32'(lock_len), 32'(LOCK_CYCLES));
        check("fail_after_lock", 32'(fail_cnt), 32'd0);
        lock_len = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    pulse_p = 1'b0;
    key     = 1'b0;
    code    = 4'b1011;
    idle(2);
    check("rst_result", 32'(result), 32'd0);
    check("rst_res_en", 32'(res_en), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    rst = 1'b0;
    idle(2);

    // Correct entry
    entry(4'b1011, 1'b1, 1'b0, 2'd0);

    // Lockout after three wrong entries; strobes during lock are ignored
    entry(4'b1001, 1'b0, 1'b0, 2'd1);
    entry(4'b1001, 1'b0, 1'b0, 2'd2);
    entry(4'b1001, 1'b0, 1'b1, 2'd3);
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    begin
      int n;
      n = 0;
      while (locked && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("unlock_bound", 32'(locked), 32'd0);
    end
    idle(2);

    // Recovery: two failures then a match clears fail_cnt
    entry(4'b1001, 1'b0, 1'b0, 2'd1);
    entry(4'b1001, 1'b0, 1'b0, 2'd2);
    entry(4'b1011, 1'b1, 1'b0, 2'd0);

    // Gap shorter than the timeout keeps the partial entry
    expect_res(1'b1, 1'b0, 2'd0);
    strobe(1'b1);
    strobe(1'b0);
    idle(60);
    strobe(1'b1);
    strobe(1'b1);

    // Gap longer than the timeout discards the partial entry
    strobe(1'b1);
    strobe(1'b0);
    idle(70);
    entry(4'b1011, 1'b1, 1'b0, 2'd0);

    // Held strobe yields a single bit
    key     = 1'b1;
    pulse_p = 1'b1;
    idle(10);
    pulse_p = 1'b0;
    idle(1);
    expect_res(1'b1, 1'b0, 2'd0);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b1);

    // Reset mid-entry aborts everything
    entry(4'b1001, 1'b0, 1'b0, 2'd1);
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    rst = 1'b1;
    idle(1);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_res_en", 32'(res_en), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_fail_cnt", 32'(fail_cnt), 32'd0);
    rst = 1'b0;
    idle(1);
    entry(4'b1011, 1'b1, 1'b0, 2'd0);

    idle(5);
    check("pending_expected", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
